// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and defaults for the UART TX arbiter.
// Used by uart_tx_arbiter and rr_pick.
package uart_arb_pkg;

  localparam int unsigned UART_DW         = 8;
  localparam int unsigned BURST_W         = 8;
  localparam int unsigned DEF_MAX_BURST   = 80;
  localparam int unsigned DEF_TIMEOUT_CYC = 1000000;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin select.
// Searches from the index after last_i, wrapping, for the first valid bit.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int unsigned j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      j = (32'(last_i) + k) % N;
      if (!any_o && valid_i[IW'(j)]) begin
        gnt_o[IW'(j)] = 1'b1;
        idx_o         = IW'(j);
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one UART TX.
// Optional handshake watchdog: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned MAX_BURST   = DEF_MAX_BURST,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [UART_DW*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic                       tx_start_o,
  output logic [UART_DW-1:0]         tx_data_o,
  input  logic                       tx_ready_i,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam logic [BURST_W-1:0] BURST_CAP = BURST_W'(MAX_BURST);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("uart_tx_arbiter: NUM_REQ must be 2..8");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("uart_tx_arbiter: MAX_BURST must be 1..255");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_tmo
    $error("uart_tx_arbiter: TIMEOUT_CYC must be >= 1");
  end

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        own_q, own_d;
  logic [IW-1:0]        last_grant_q, last_grant_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic                 last_q, last_d;
  logic [UART_DW-1:0]   tx_data_q, tx_data_d;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;
  logic [UART_DW-1:0]   sel_data;
  logic                 sel_last;
  logic                 accept;
  logic                 sent;
  logic                 done;
  logic                 tmo;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_pick (
    .valid_i (req_valid_i),
    .last_i  (last_grant_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // grant_q is one-hot, so an OR-mux picks the owner's byte
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q[i]) begin
        sel_data |= req_data_i[i*UART_DW +: UART_DW];
        sel_last |= req_last_i[i];
      end
    end
  end

  assign req_ready_o = (state_q == SEND)
                     ? (grant_q & req_valid_i & {NUM_REQ{tx_ready_i}})
                     : '0;
  assign accept = |req_ready_o;

  assign sent = (state_q == WAIT_DONE && tx_ready_i) || tmo;
  assign done = last_q || (burst_q == BURST_CAP);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;
  logic          waiting;

  assign waiting = (state_q == WAIT_BUSY) || (state_q == WAIT_DONE);

  always_comb begin
    tmo_cnt_d = '0;
    err_d     = err_q;
    tmo       = 1'b0;
    if (waiting) begin
      if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
        tmo   = 1'b1;
        err_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign tmo   = 1'b0;
  assign err_o = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    own_d        = own_q;
    last_grant_d = last_grant_q;
    burst_d      = burst_q;
    last_d       = last_q;
    tx_data_d    = tx_data_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any && tx_ready_i) begin
          grant_d = pick_gnt;
          own_d   = pick_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          tx_data_d = sel_data;
          last_d    = sel_last;
          burst_d   = burst_q + 1'b1;
          state_d   = START;
        end
      end
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (!tx_ready_i) state_d = WAIT_DONE;
      WAIT_DONE: state_d = WAIT_DONE;
      default:   state_d = IDLE;
    endcase
    // byte finished (or watchdog fired): release or keep the lock
    if (sent) begin
      if (done) begin
        grant_d      = '0;
        last_grant_d = own_q;
        burst_d      = '0;
        state_d      = IDLE;
      end else begin
        state_d = SEND;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      own_q        <= '0;
      last_grant_q <= IW'(NUM_REQ - 1);
      burst_q      <= '0;
      last_q       <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      own_q        <= own_d;
      last_grant_q <= last_grant_d;
      burst_q      <= burst_d;
      last_q       <= last_d;
      tx_data_q    <= tx_data_d;
    end
  end

  assign grant_o    = grant_q;
  assign tx_start_o = (state_q == START);
  assign tx_data_o  = tx_data_q;
  assign busy_o     = (state_q != IDLE);

endmodule
